cam_capture: RTL
================

Name: cam_capture

Overview:
- Write-side producer for the dual-port frame buffer.
- Samples an OV7670-style camera bus (pclk domain, vsync/href, 8-bit data in RGB444 two-byte format) and assembles 12-bit pixels.
- Drives the buffer's write port with address, data and write enable, one pixel per two valid bytes.
- Raster-order addressing from 0 up to IMG_W*IMG_H-1. The address IMG_W*IMG_H is reserved for black and is never written.

Parameters:
- AW, 15: address width; must match the frame buffer.
- DW, 12: pixel width (RGB444); fixed by format.
- IMG_W, 160: pixels per line.
- IMG_H, 120: lines per frame.

Ports:
- clk  input  1: camera pixel clock (pclk); all logic on rising edge.
- reset  input  1: asynchronous, active-low reset.
- init  input  1: capture enable; level-sensitive.
- vsync  input  1: camera frame sync; high = vertical blanking.
- href  input  1: camera line valid; high = data bytes valid.
- px_data  input  8: camera data byte.
- mem_px_addr  output  AW: write address to frame buffer.
- mem_px_data  output  DW: write data to frame buffer.
- px_wr  output  1: write enable to frame buffer.
- frame_done  output  1: one-cycle pulse at end of captured frame.
- overflow  output  1: sticky; frame delivered more than IMG_W*IMG_H pixels.

Behaviour:
- Reset (reset=0, async): state IDLE; mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, overflow=0, byte phase=0, pixel count=0.
- FSM states:
  - IDLE: init=1 -> WAIT_FRAME.
  - WAIT_FRAME: wait for a vsync falling edge (vsync=1 sampled, then vsync=0). Clear count, phase and overflow, then -> CAPTURE.
  - CAPTURE: see below.
  - DONE: one cycle; frame_done=1. If init=1 -> WAIT_FRAME, else -> IDLE.
- Edge detection uses a registered copy of vsync; a frame already in progress when init rises is skipped.
- Byte assembly in CAPTURE:
  - Byte is valid on a clk edge where href=1.
  - Phase 0: latch px_data[3:0] as R.
  - Phase 1: latch px_data[7:4] as G and px_data[3:0] as B.
  - Phase toggles every valid byte.
- Write timing:
  - On the cycle after a phase-1 byte: px_wr=1, mem_px_data={R,G,B}, mem_px_addr=pixel count.
  - Count increments after the write. Latency is one clk from the second byte to px_wr.
- px_wr is a single-cycle pulse per pixel; 0 otherwise. mem_px_addr and mem_px_data hold their last values when px_wr=0.
- href falls with phase=1 (odd byte count in a line): partial pixel discarded, phase reset to 0, no write.
- Count reaches IMG_W*IMG_H: further completed pixels produce no px_wr; overflow=1 until the next frame start.
- vsync rises in CAPTURE: a pending complete pixel is still written that cycle; the FSM then goes to DONE. A frame with fewer pixels still completes normally.
- init falls mid-frame: current frame finishes; DONE then -> IDLE.
- Width rules:
  - Count is AW bits.
  - Comparison is against the IMG_W*IMG_H localparam.
  - Elaboration requires IMG_W*IMG_H < 2**AW.
- reset asserted mid-frame: immediate return to IDLE with reset values. After release, no write occurs until a full vsync high->low is seen.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, WAIT_FRAME, CAPTURE, DONE);
  - the RGB444 field positions;
  - IMG_W, IMG_H and the derived NPIX = IMG_W*IMG_H, reused by the buffer's black-pixel slot and the VGA reader.
- One natural sub-module: cam_byte_pack, holding the phase toggle, the R/G/B latches and the pixel-complete strobe. The FSM, address counter and flags stay in the top.

Test Plan:
1. IMG_W=2, IMG_H=2. init=1, vsync 1->0, two lines of href=1 for 4 bytes each (0x0F,0xAB, 0x01,0x23 ...) -> px_wr pulses at addr 0..3, mem_px_data 0xFAB, 0x123, ...; frame_done pulses once after vsync rises.
2. Line with 3 bytes (0x05,0x67,0x08) -> one write of 0x567; the trailing byte is dropped; the next line starts at phase 0.
3. Frame of 6 pixels with IMG_W*IMG_H=4 -> exactly 4 writes at addr 0..3; overflow=1 after the 5th pixel; overflow clears at the next vsync falling edge.
4. init rises while vsync=0 mid-frame -> no writes until vsync goes 1 then 0; first write lands at addr 0.
5. reset pulsed low during pixel 2 -> all outputs 0 asynchronously; no px_wr until a new vsync falling edge; capture restarts at addr 0.
6. init held 1 across two frames -> two frame_done pulses; the second frame's first write is at addr 0 with correct data.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg: shared state encoding, RGB444 layout and frame geometry
package cam_capture_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;
  localparam int PIX_W = 12;
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int NPIX = IMG_W * IMG_H;
  function automatic logic [PIX_W-1:0] rgb444(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    logic [PIX_W-1:0] p;
    p = '0;
    p[R_LSB+:4] = r;
    p[G_LSB+:4] = g;
    p[B_LSB+:4] = b;
    return p;
  endfunction
endpackage

// File: rtl/cam_capture_byte_pack.sv
// cam_byte_pack: pairs camera bytes into RGB444 pixels; phase drops to 0 whenever href is low
module cam_byte_pack
  import cam_capture_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [7:0]       px_data,
  output logic             pix_done,
  output logic [PIX_W-1:0] pix
);
  logic       phase;
  logic [3:0] r;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      phase <= 1'b0;
      r <= '0;
    end else begin
      phase <= en & ~phase;
      if (en && !phase) r <= px_data[3:0];
    end
  // G and B come straight off the bus so the write lands one clock after the second byte
  assign pix_done = en & phase;
  assign pix = rgb444(r, px_data[7:4], px_data[3:0]);
endmodule

// File: rtl/cam_capture.sv
// cam_capture: captures an OV7670 RGB444 frame and writes it into the frame buffer in raster order
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 12,
  parameter int IMG_W = cam_capture_pkg::IMG_W,
  parameter int IMG_H = cam_capture_pkg::IMG_H
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          overflow
);
  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST = AW'(FRAME_PIX);
  if (FRAME_PIX >= 2**AW) begin : g_chk
    $error("IMG_W*IMG_H must be below 2**AW");
  end
  state_t           state;
  logic             vsync_q;
  logic [AW-1:0]    count;
  logic             pix_done;
  logic [PIX_W-1:0] pix;
  cam_byte_pack u_pack (
    .clk(clk),
    .reset(reset),
    .en(state == CAPTURE && href),
    .px_data(px_data),
    .pix_done(pix_done),
    .pix(pix)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      vsync_q <= 1'b0;
      count <= '0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr <= 1'b0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      vsync_q <= vsync;
      px_wr <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (init) state <= WAIT_FRAME;
        WAIT_FRAME: if (vsync_q && !vsync) begin
          count <= '0;
          overflow <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          // the slot at LAST is the buffer's black pixel, so it is never written
          if (pix_done && count != LAST) begin
            px_wr <= 1'b1;
            mem_px_addr <= count;
            mem_px_data <= DW'(pix);
            count <= count + 1'b1;
          end else if (pix_done) overflow <= 1'b1;
          if (vsync) begin
            state <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: state <= init ? WAIT_FRAME : IDLE;
      endcase
    end
endmodule
